snail_pattern_gen: RTL and testbench
====================================

Name: snail_pattern_gen

Overview:
- Serial pattern transmitter; the source end of the one-bit serial line that the snail sequence detectors consume.
- Accepts a parallel pattern and framing settings through a start/ready handshake.
- Shifts the pattern out MSB-first on D, repeating it a programmable number of times with programmable idle gaps.
- Used as the stimulus/loopback source for detector FSMs and as a standalone serial generator.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- CNTW, 16, width of the completed-pattern counter.

Ports:
- clk  input  1  rising-edge clock.
- _rst  input  1  synchronous reset, active-high (asserted = 1, sampled on posedge clk).
- start  input  1  request to begin a transmission.
- pattern  input  WIDTH  bits to send; only the nbits LSBs are used.
- nbits  input  $clog2(WIDTH+1)  pattern length; 0 or any value > WIDTH is treated as WIDTH.
- reps  input  8  number of repetitions; 0 is treated as 1.
- gap  input  4  idle cycles between repetitions.
- D  output  1  serial data, registered.
- bit_valid  output  1  D carries a pattern bit this cycle.
- busy  output  1  transmission in progress.
- ready  output  1  equals ~busy.
- done  output  1  one-cycle pulse after the final bit of the final repetition.
- sent_cnt  output  CNTW  repetitions completed since reset; saturates at all-ones.

Behaviour:
- Reset: _rst=1 at a posedge forces state IDLE, D=0, bit_valid=0, busy=0, done=0, sent_cnt=0, and clears all latched config. Reset takes priority over every other input, including mid-transmission; the stream is aborted with no done pulse.
- States: IDLE, SEND, GAP. All outputs are registered.
- IDLE:
  - start=1 at edge k latches pattern, effective nbits (N), effective reps (R) and gap (G).
  - After edge k: state=SEND, busy=1, bit_valid=1, D=pattern[N-1].
  - start with busy=1 is ignored; the latched config is unchanged.
- SEND:
  - One bit per cycle, order pattern[N-1] down to pattern[0]. The bit index decrements each edge.
  - At the edge ending bit 0, sent_cnt increments (saturating) and the repetition counter decrements. Then:
    - Repetitions remain and G>0: state=GAP, D=0, bit_valid=0, busy=1, for exactly G cycles, then SEND restarting at pattern[N-1].
    - Repetitions remain and G=0: back-to-back. The next cycle is D=pattern[N-1] with bit_valid continuously 1.
    - Last repetition: state=IDLE, busy=0, bit_valid=0, D=0, done=1 for exactly one cycle.
- Latency: the first bit appears in the cycle immediately after the accepting edge.
- Total busy cycles = R*N + (R-1)*G.
- start=1 during the done cycle is accepted, since busy=0 there. The next stream starts the following cycle; done still pulses only once.
- N=1 is legal: one bit per repetition.
- D is always 0 whenever bit_valid=0.

Test Plan:
- Single pattern: WIDTH=8, pattern=8'b1011_0011, nbits=8, reps=1, gap=0, start 1 cycle.
  - Required: D=1,0,1,1,0,0,1,1 with bit_valid=1 for 8 cycles.
  - Required: done=1 in cycle 9, busy=0, sent_cnt=1.
- Partial length: pattern=8'hAB, nbits=4.
  - Required: D=1,0,1,1 (low nibble).
  - nbits=0 or 9 with pattern=8'hAB sends 1,0,1,0,1,0,1,1.
- Repeat with gap: pattern=3'b110, nbits=3, reps=3, gap=2.
  - Required: D stream 1,1,0,0,0,1,1,0,0,0,1,1,0, with bit_valid low in the 4 gap cycles.
  - Required: busy=1 for 13 cycles, then a single done pulse; sent_cnt increases by 3.
- Back-to-back: same pattern with gap=0, reps=2.
  - Required: D=1,1,0,1,1,0, bit_valid continuously 1, done after cycle 6.
- Handshake:
  - start held high through a transmission has no effect while busy=1; pattern changes mid-stream do not alter D.
  - start high in the done cycle starts a new stream on the next cycle.
- Reset mid-operation: _rst=1 after bit 3 of an 8-bit send.
  - Required: next cycle D=0, bit_valid=0, busy=0, done=0, sent_cnt=0.
  - A subsequent start transmits normally from pattern[N-1].

Source files
------------

// File: rtl/snail_pattern_gen.sv
// rtl/snail_pattern_gen.sv - serial pattern transmitter, MSB-first with repeats and idle gaps
module snail_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16,
  localparam int NW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [NW-1:0]    nbits,
  input  logic [7:0]       reps,
  input  logic [3:0]       gap,
  output logic             D,
  output logic             bit_valid,
  output logic             busy,
  output logic             ready,
  output logic             done,
  output logic [CNTW-1:0]  sent_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [NW-1:0] WIDTH_N = NW'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] aligned_q;   // pattern shifted so bit N-1 sits at the MSB
  logic [WIDTH-1:0] shift_q;     // remaining bits of the current repetition, MSB next
  logic [NW-1:0]    n_q;         // effective pattern length
  logic [NW-1:0]    bits_left_q; // bits still to send after the one on D
  logic [7:0]       rep_q;       // repetitions remaining, including the current one
  logic [3:0]       gap_q;       // latched idle gap length
  logic [3:0]       gap_cnt_q;   // gap cycles remaining after the current one
  logic             d_q;
  logic             bit_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNTW-1:0]  sent_cnt_q;

  logic [NW-1:0]    n_d;
  logic [7:0]       rep_d;
  logic [WIDTH-1:0] aligned_d;
  logic [CNTW-1:0]  sent_cnt_d;

  // Effective config from the request inputs and the saturating repetition count
  always_comb begin
    n_d        = nbits;
    rep_d      = reps;
    aligned_d  = '0;
    sent_cnt_d = sent_cnt_q;
    if (nbits == '0 || nbits > WIDTH_N) begin
      n_d = WIDTH_N;
    end
    if (reps == 8'd0) begin
      rep_d = 8'd1;
    end
    // Left-align so the unused upper bits fall off the top of the shifter
    aligned_d = pattern << (WIDTH_N - n_d);
    if (sent_cnt_q != '1) begin
      sent_cnt_d = sent_cnt_q + CNTW'(1);
    end
  end

  // Transmit FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q     <= IDLE;
      aligned_q   <= '0;
      shift_q     <= '0;
      n_q         <= '0;
      bits_left_q <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      d_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            aligned_q   <= aligned_d;
            n_q         <= n_d;
            rep_q       <= rep_d;
            gap_q       <= gap;
            d_q         <= aligned_d[WIDTH-1];
            shift_q     <= aligned_d << 1;
            bits_left_q <= n_d - NW'(1);
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end

        SEND: begin
          if (bits_left_q != '0) begin
            d_q         <= shift_q[WIDTH-1];
            shift_q     <= shift_q << 1;
            bits_left_q <= bits_left_q - NW'(1);
          end else begin
            // Edge ending bit 0 of a repetition
            sent_cnt_q <= sent_cnt_d;
            rep_q      <= rep_q - 8'd1;
            if (rep_q != 8'd1) begin
              if (gap_q != 4'd0) begin
                d_q         <= 1'b0;
                bit_valid_q <= 1'b0;
                gap_cnt_q   <= gap_q - 4'd1;
                state_q     <= GAP;
              end else begin
                d_q         <= aligned_q[WIDTH-1];
                shift_q     <= aligned_q << 1;
                bits_left_q <= n_q - NW'(1);
              end
            end else begin
              d_q         <= 1'b0;
              bit_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end

        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            d_q         <= aligned_q[WIDTH-1];
            shift_q     <= aligned_q << 1;
            bits_left_q <= n_q - NW'(1);
            bit_valid_q <= 1'b1;
            state_q     <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end

        default: begin
          d_q         <= 1'b0;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign D         = d_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign ready     = ~busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_snail_pattern_gen.sv
// tb/tb_snail_pattern_gen.sv - scoreboard bench for snail_pattern_gen
module tb_snail_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [3:0]       nbits;
  logic [7:0]       reps;
  logic [3:0]       gap;
  logic             D;
  logic             bit_valid;
  logic             busy;
  logic             ready;
  logic             done;
  logic [CNTW-1:0]  sent_cnt;

  always #5 clk = ~clk;

  snail_pattern_gen #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk),
    ._rst(rst),
    .start(start),
    .pattern(pattern),
    .nbits(nbits),
    .reps(reps),
    .gap(gap),
    .D(D),
    .bit_valid(bit_valid),
    .busy(busy),
    .ready(ready),
    .done(done),
    .sent_cnt(sent_cnt)
  );

  // flags = {busy, bit_valid, D, done}
  typedef struct {
    logic [3:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks  = 0;
  int   fails   = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // '1'/'0' = pattern bit, '-' = gap cycle
  task automatic push_bits(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1")      e.flags = 4'b1110;
      else if (s[i] == "0") e.flags = 4'b1100;
      else                  e.flags = 4'b1000;
      e.cnt = '0;
      expq.push_back(e);
    end
  endtask

  task automatic expect_stream(input string s, input int r);
    exp_t e;
    push_bits(s);
    exp_cnt += r;
    e.flags = 4'b0001;
    e.cnt   = exp_cnt[15:0];
    expq.push_back(e);
  endtask

  task automatic issue(input logic [7:0] p, input logic [3:0] nb, input logic [7:0] rp,
                       input logic [3:0] gp);
    @(posedge clk);
    #1;
    pattern = p;
    nbits   = nb;
    reps    = rp;
    gap     = gp;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  // Monitor: every cycle the DUT is busy or pulsing done must match the next expected entry
  always @(negedge clk) begin
    if (busy === 1'b1 || done === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: busy=%b bit_valid=%b D=%b done=%b, required no activity",
                 busy, bit_valid, D, done);
      end else begin
        mon_e = expq.pop_front();
        if ({busy, bit_valid, D, done} !== mon_e.flags) begin
          fails++;
          $display("FAIL stream: {busy,bit_valid,D,done}=%b required %b",
                   {busy, bit_valid, D, done}, mon_e.flags);
        end
        if (mon_e.flags == 4'b0001) begin
          checks++;
          if (sent_cnt !== mon_e.cnt) begin
            fails++;
            $display("FAIL sent_cnt_at_done: got %0d required %0d", sent_cnt, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = '0;
    nbits   = '0;
    reps    = '0;
    gap     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_D", D, 0);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_sent_cnt", sent_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single full-width pattern
    expect_stream("10110011", 1);
    issue(8'b1011_0011, 4'd8, 8'd1, 4'd0);
    wait_done("single");

    // Partial length and out-of-range lengths
    expect_stream("1011", 1);
    issue(8'hAB, 4'd4, 8'd1, 4'd0);
    wait_done("nbits4");
    expect_stream("10101011", 1);
    issue(8'hAB, 4'd0, 8'd1, 4'd0);
    wait_done("nbits0");
    expect_stream("10101011", 1);
    issue(8'hAB, 4'd9, 8'd1, 4'd0);
    wait_done("nbits9");

    // Repeats with gap, then back-to-back
    expect_stream("110--110--110", 3);
    issue(8'b0000_0110, 4'd3, 8'd3, 4'd2);
    wait_done("gap2");
    expect_stream("110110", 2);
    issue(8'b0000_0110, 4'd3, 8'd2, 4'd0);
    wait_done("b2b");

    // One-bit pattern, and reps=0 treated as one
    expect_stream("1-1-1", 3);
    issue(8'h01, 4'd1, 8'd3, 4'd1);
    wait_done("n1");
    expect_stream("1011", 1);
    issue(8'hAB, 4'd4, 8'd0, 4'd0);
    wait_done("reps0");

    // start held through a stream, config changes mid-stream, restart in the done cycle
    expect_stream("0101-0101", 2);
    expect_stream("110", 1);
    @(posedge clk);
    #1;
    pattern = 8'hC5;
    nbits   = 4'd4;
    reps    = 8'd2;
    gap     = 4'd1;
    start   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pattern = 8'h0E;
    nbits   = 4'd3;
    reps    = 8'd1;
    gap     = 4'd0;
    wait_done("held_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("held_second");

    // Reset after bit 3 of an 8-bit stream
    push_bits("101");
    issue(8'b1011_0011, 4'd8, 8'd1, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_D", D, 0);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sent_cnt", sent_cnt, 0);
    chk("midrst_queue_drained", expq.size(), 0);
    exp_cnt = 0;
    expect_stream("10110011", 1);
    issue(8'b1011_0011, 4'd8, 8'd1, 4'd0);
    wait_done("after_rst");

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", expq.size(), 0);
    chk("final_ready", ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
